// File: rtl/cpu_mem_pkg.sv
// Shared types for the MEM stage bus controller.
//   bus_state_e : bus access state machine encoding
//   MEMTOREG_*  : writeback mux select values (passed through, not decoded here)
//   wb_t        : MEM/WB register bundle; WB_BUBBLE is the all-zero no-op entry
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bus_state_e;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] mem_data;
        logic [31:0] pc_next;
        logic [4:0]  write_addr;
        logic [1:0]  memtoreg;
        logic        regwrite;
    } wb_t;

    localparam wb_t        WB_BUBBLE   = '0;
    localparam logic [31:0] BUBBLE_WORD = 32'h0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, reset   : clock, async active-high reset (clears to a bubble)
//   load_bubble  : load the all-zero bubble (wins over load_data)
//   load_data    : load wb_d
//   wb_d / wb_q  : next / current MEM/WB bundle
module mem_wb_reg
    import cpu_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_bubble,
    input  logic load_data,
    input  wb_t  wb_d,
    output wb_t  wb_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            wb_q <= WB_BUBBLE;
        else if (load_bubble) wb_q <= WB_BUBBLE;
        else if (load_data)   wb_q <= wb_d;
    end

endmodule

// File: rtl/mem_stage_bus_ctrl.sv
// MEM stage: performs loads/stores over a req/gnt/rvalid bus, stalls the
// pipeline while an access is outstanding, and drives the MEM/WB register.
//   clk, reset                : clock, async active-high reset
//   alu_out_in .. RegWrite_in : EX/MEM fields
//   stall                     : combinational hold for EX/MEM and earlier
//   mem_req/we/addr/wdata     : registered bus request
//   mem_gnt/rvalid/rdata      : bus responses
//   bus_err                   : one-cycle pulse on misalignment or timeout
//   wb_*                      : MEM/WB outputs
module mem_stage_bus_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rt_in,
    input  logic [4:0]  write_addr_in,
    input  logic [31:0] pc_next_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemtoReg_in,
    input  logic        RegWrite_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_pc_next,
    output logic [4:0]  wb_write_addr,
    output logic [1:0]  wb_MemtoReg,
    output logic        wb_RegWrite
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_e  state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [31:0] rdata_hold;
    logic        timed_out;

    logic access, misaligned, tmo_hit;
    logic start, req_clr, err_set, capture, to_set;
    logic load_bubble, load_data;
    wb_t  wb_d, wb_q;

    assign access     = MemRead_in | MemWrite_in;
    assign misaligned = access & (alu_out_in[1:0] != 2'b00);
    // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
    assign tmo_hit    = (tmo_cnt + 1'b1) == CW'(TIMEOUT_CYCLES);

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        load_bubble = 1'b0;
        load_data   = 1'b0;
        start       = 1'b0;
        req_clr     = 1'b0;
        err_set     = 1'b0;
        capture     = 1'b0;
        to_set      = 1'b0;
        wb_d        = '{alu_out:    alu_out_in,
                        mem_data:   BUBBLE_WORD,
                        pc_next:    pc_next_in,
                        write_addr: write_addr_in,
                        memtoreg:   MemtoReg_in,
                        regwrite:   RegWrite_in};
        case (state)
            IDLE: begin
                if (!access) begin
                    load_data = 1'b1;
                end else begin
                    load_bubble = 1'b1;
                    if (misaligned) begin
                        err_set = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        start     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall       = 1'b1;
                load_bubble = 1'b1;
                // A bus response on the final cycle still completes the access.
                if (mem_gnt) begin
                    req_clr = 1'b1;
                    if (mem_we) begin
                        state_nxt = DONE;
                    end else if (mem_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (tmo_hit) begin
                    req_clr   = 1'b1;
                    err_set   = 1'b1;
                    to_set    = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                stall       = 1'b1;
                load_bubble = 1'b1;
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    err_set   = 1'b1;
                    to_set    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_data     = 1'b1;
                wb_d.mem_data = timed_out ? BUBBLE_WORD : rdata_hold;
                if (timed_out) wb_d.regwrite = 1'b0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_err    <= 1'b0;
            tmo_cnt    <= '0;
            rdata_hold <= '0;
            timed_out  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= err_set;
            if (start) begin
                mem_req    <= 1'b1;
                mem_we     <= MemWrite_in;  // both set → store
                mem_addr   <= {alu_out_in[31:2], 2'b00};
                mem_wdata  <= rt_in;
                tmo_cnt    <= '0;
                rdata_hold <= '0;           // stores write back 0
                timed_out  <= 1'b0;
            end else begin
                if (req_clr) mem_req <= 1'b0;
                if (state == REQ || state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
                if (capture) rdata_hold <= mem_rdata;
                if (to_set)  timed_out  <= 1'b1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .reset       (reset),
        .load_bubble (load_bubble),
        .load_data   (load_data),
        .wb_d        (wb_d),
        .wb_q        (wb_q)
    );

    assign wb_alu_out    = wb_q.alu_out;
    assign wb_mem_data   = wb_q.mem_data;
    assign wb_pc_next    = wb_q.pc_next;
    assign wb_write_addr = wb_q.write_addr;
    assign wb_MemtoReg   = wb_q.memtoreg;
    assign wb_RegWrite   = wb_q.regwrite;

endmodule

// File: tb/tb_mem_stage_bus_ctrl.sv
// Directed bench for mem_stage_bus_ctrl (TIMEOUT_CYCLES = 4).
module tb_mem_stage_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_out_in, rt_in, pc_next_in;
    logic [4:0]  write_addr_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic        stall, mem_req, mem_we, bus_err;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] wb_alu_out, wb_mem_data, wb_pc_next;
    logic [4:0]  wb_write_addr;
    logic [1:0]  wb_MemtoReg;
    logic        wb_RegWrite;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .alu_out_in(alu_out_in), .rt_in(rt_in), .write_addr_in(write_addr_in),
        .pc_next_in(pc_next_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err),
        .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_pc_next(wb_pc_next),
        .wb_write_addr(wb_write_addr), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // registered outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_out_in = 0; rt_in = 0; pc_next_in = 0; write_addr_in = 0;
        MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #12;
        chk("rst_mem_req",  mem_req, 0);
        chk("rst_bus_err",  bus_err, 0);
        chk("rst_wb_rw",    wb_RegWrite, 0);
        chk("rst_wb_alu",   wb_alu_out, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        // 1. ALU op: no stall, wb valid next cycle
        RegWrite_in = 1; write_addr_in = 5; alu_out_in = 32'h10; pc_next_in = 32'h44;
        #1 chk("alu_stall", stall, 0);
        tick();
        chk("alu_wb_rw",   wb_RegWrite, 1);
        chk("alu_wb_wa",   wb_write_addr, 5);
        chk("alu_wb_alu",  wb_alu_out, 32'h10);
        chk("alu_wb_pc",   wb_pc_next, 32'h44);
        chk("alu_wb_md",   wb_mem_data, 0);
        chk("alu_stall2",  stall, 0);
        chk("alu_req",     mem_req, 0);

        // 2. Load: gnt in REQ, rvalid in WAIT
        MemRead_in = 1; alu_out_in = 32'h100; RegWrite_in = 1; write_addr_in = 7;
        MemtoReg_in = 2'd1; pc_next_in = 32'h48;
        #1 chk("ld_stall1", stall, 1);
        tick();                                    // REQ
        chk("ld_req",      mem_req, 1);
        chk("ld_addr",     mem_addr, 32'h100);
        chk("ld_we",       mem_we, 0);
        chk("ld_stall2",   stall, 1);
        chk("ld_bub_rw",   wb_RegWrite, 0);
        chk("ld_bub_wa",   wb_write_addr, 0);
        mem_gnt = 1;
        tick();                                    // WAIT
        mem_gnt = 0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_stall3",   stall, 1);
        chk("ld_bub_rw2",  wb_RegWrite, 0);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();                                    // DONE
        mem_rvalid = 0; mem_rdata = 0;
        chk("ld_done_stall", stall, 0);
        tick();                                    // IDLE, wb from DONE
        nop();
        chk("ld_wb_md",    wb_mem_data, 32'hDEADBEEF);
        chk("ld_wb_rw",    wb_RegWrite, 1);
        chk("ld_wb_wa",    wb_write_addr, 7);
        chk("ld_wb_m2r",   wb_MemtoReg, 1);
        chk("ld_wb_pc",    wb_pc_next, 32'h48);

        // 3. Store: gnt on first REQ cycle
        MemWrite_in = 1; alu_out_in = 32'h204; rt_in = 32'h12345678; RegWrite_in = 0;
        #1 chk("st_stall1", stall, 1);
        tick();                                    // REQ
        chk("st_req",   mem_req, 1);
        chk("st_we",    mem_we, 1);
        chk("st_wdata", mem_wdata, 32'h12345678);
        chk("st_addr",  mem_addr, 32'h204);
        chk("st_stall2", stall, 1);
        mem_gnt = 1;
        tick();                                    // DONE
        mem_gnt = 0;
        chk("st_req_drop", mem_req, 0);
        chk("st_done_stall", stall, 0);
        tick();
        nop();
        chk("st_wb_rw",  wb_RegWrite, 0);
        chk("st_wb_md",  wb_mem_data, 0);
        chk("st_wb_alu", wb_alu_out, 32'h204);

        // 4. Misaligned load
        MemRead_in = 1; alu_out_in = 32'h102; RegWrite_in = 1; write_addr_in = 4;
        #1 chk("mis_stall", stall, 0);
        tick();
        nop();
        chk("mis_err",   bus_err, 1);
        chk("mis_req",   mem_req, 0);
        chk("mis_wb_rw", wb_RegWrite, 0);
        tick();
        chk("mis_err_pulse", bus_err, 0);
        chk("mis_req2",  mem_req, 0);

        // 5. Timeout: gnt never arrives
        MemRead_in = 1; alu_out_in = 32'h300; RegWrite_in = 1; write_addr_in = 6;
        tick();                                    // REQ cycle 1
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), mem_req, 1);
            chk($sformatf("to_err%0d", i), bus_err, 0);
            tick();
        end
        chk("to_err",        bus_err, 1);          // DONE
        chk("to_req_drop",   mem_req, 0);
        chk("to_done_stall", stall, 0);
        tick();
        nop();
        chk("to_wb_rw",  wb_RegWrite, 0);
        chk("to_wb_md",  wb_mem_data, 0);
        chk("to_err_pulse", bus_err, 0);
        #1 chk("to_resume_stall", stall, 0);

        // 6a. Reset while in REQ: mem_req drops without a clock edge
        MemRead_in = 1; alu_out_in = 32'h400; RegWrite_in = 1; write_addr_in = 9;
        tick();                                    // REQ
        chk("rr_req", mem_req, 1);
        #1 reset = 1'b1;
        #1 chk("rr_req_drop", mem_req, 0);
        #1 reset = 1'b0;
        // 6b. Reset while in WAIT
        tick();                                    // IDLE -> REQ
        mem_gnt = 1;
        tick();                                    // WAIT
        mem_gnt = 0;
        chk("rw_stall", stall, 1);
        #1 reset = 1'b1;
        nop();
        #1;
        chk("rw_req",   mem_req, 0);
        chk("rw_wb_rw", wb_RegWrite, 0);
        chk("rw_wb_wa", wb_write_addr, 0);
        chk("rw_wb_alu", wb_alu_out, 0);
        chk("rw_stall_idle", stall, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_after_req", mem_req, 0);
        // new load, gnt and rvalid together
        MemRead_in = 1; alu_out_in = 32'h500; RegWrite_in = 1; write_addr_in = 3;
        MemtoReg_in = 2'd1;
        tick();                                    // REQ
        chk("nl_addr", mem_addr, 32'h500);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        tick();                                    // DONE
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        chk("nl_done_stall", stall, 0);
        chk("nl_req_drop",   mem_req, 0);
        tick();
        nop();
        chk("nl_wb_md", wb_mem_data, 32'hCAFEF00D);
        chk("nl_wb_rw", wb_RegWrite, 1);
        chk("nl_wb_wa", wb_write_addr, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_bus_ctrl.md
Name: mem_stage_bus_ctrl

Overview:
Consumer end of the EX/MEM pipeline interface. It takes the MEM-stage fields (ALU result, rt store data, write address, pc_next, MemRead/MemWrite, MemtoReg/RegWrite) and performs the data access over a req/gnt/rvalid memory bus. It stalls the pipeline while an access is outstanding and drives the registered MEM/WB outputs consumed by writeback.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before the access is aborted with bus_err (counter width is ceil(log2(TIMEOUT_CYCLES+1))).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_out_in  input  32  EX/MEM ALU result; memory byte address for loads/stores
rt_in  input  32  EX/MEM store data
write_addr_in  input  5  EX/MEM destination register
pc_next_in  input  32  EX/MEM pc+4, used for link writes
MemRead_in  input  1  load request
MemWrite_in  input  1  store request
MemtoReg_in  input  2  writeback mux select, passed through
RegWrite_in  input  1  writeback enable, passed through
stall  output  1  combinational; high means EX/MEM and earlier stages must hold
mem_req  output  1  registered bus request
mem_we  output  1  registered; 1 = store
mem_addr  output  32  registered word address ({alu_out[31:2],2'b00})
mem_wdata  output  32  registered store data
mem_gnt  input  1  bus accepted request this cycle
mem_rvalid  input  1  read data valid this cycle
mem_rdata  input  32  read data
bus_err  output  1  registered one-cycle pulse on misalignment or timeout
wb_alu_out, wb_mem_data, wb_pc_next  output  32 each  MEM/WB data
wb_write_addr  output  5  MEM/WB destination
wb_MemtoReg  output  2  MEM/WB mux select
wb_RegWrite  output  1  MEM/WB write enable

Behaviour:
- Reset (async): state IDLE. mem_req, mem_we, bus_err = 0. Timeout counter = 0. All wb_* = 0. mem_addr, mem_wdata = 0.
- access = MemRead_in | MemWrite_in. If both are high, treat as a store.
- misaligned = access & (alu_out_in[1:0] != 0).
- States:
  - IDLE: no access → stall=0; wb_* load inputs directly (wb_mem_data=0). Aligned access → stall=1; latch addr/wdata/we; mem_req<=1; wb_* load a bubble (all zeros); go REQ. Misaligned access → no request; stall=0; bus_err<=1; wb_* load a bubble; stay IDLE.
  - REQ: stall=1. mem_req stays high until mem_gnt. On gnt with we=1 → mem_req<=0, go DONE. On gnt for a read → mem_req<=0, go WAIT. On gnt & rvalid in the same cycle for a read → capture mem_rdata, go DONE.
  - WAIT: stall=1. On mem_rvalid → capture mem_rdata into the hold register, go DONE. A spurious rvalid in any other state is ignored.
  - DONE: stall=0. wb_* load the current inputs, with wb_mem_data = captured data (0 for stores). Go IDLE. The new instruction presented at the next IDLE cycle is a fresh access.
- Every stall cycle loads a bubble into wb_*, so WB never double-writes.
- Timeout: counter increments each cycle in REQ/WAIT and clears on entry to REQ. When it reaches TIMEOUT_CYCLES: mem_req<=0, bus_err<=1, go DONE. The DONE cycle then forces wb_RegWrite=0 and wb_mem_data=0.
- Latency: a store with same-cycle gnt stalls 2 cycles. A load with gnt then rvalid on the next cycle stalls 3 cycles. A non-memory instruction has zero stall; its wb_* are valid one cycle after inputs are presented.
- Reset mid-access: mem_req drops immediately, the state machine returns to IDLE, and the access is abandoned with no writeback.

Decomposition:
- Package cpu_mem_pkg: state encoding (IDLE, REQ, WAIT, DONE), MEMTOREG_* select constants, BUBBLE zero constants.
- One sub-module: mem_wb_reg. It holds the wb_* registers and has load_bubble / load_data controls plus the async reset. The bus state machine stays in the top level.

Test Plan:
1. ALU op: RegWrite_in=1, write_addr_in=5, alu_out_in=0x10 → next cycle wb_RegWrite=1, wb_write_addr=5, wb_alu_out=0x10; stall never asserted.
2. Load: MemRead_in=1, alu_out_in=0x100; gnt on cycle 1, rvalid with rdata=0xDEADBEEF on cycle 2 → mem_addr=0x100, mem_we=0; stall high for 3 cycles; wb_mem_data=0xDEADBEEF, wb_RegWrite=1; bubbles in wb_* during the stall.
3. Store: MemWrite_in=1, alu_out_in=0x204, rt_in=0x12345678; gnt on the first REQ cycle → mem_we=1, mem_wdata=0x12345678; stall 2 cycles; wb_RegWrite follows RegWrite_in (0).
4. Misaligned load at alu_out_in=0x102 → mem_req never rises; bus_err pulses once; wb_RegWrite=0; stall=0.
5. With TIMEOUT_CYCLES=4 and gnt never asserted → bus_err pulses after 4 REQ cycles, mem_req falls, wb_RegWrite=0; the pipeline resumes.
6. Assert reset in WAIT → mem_req=0 and all wb_*=0 immediately; after release, a new load completes normally.
